seq_alu_disp: RTL and testbench
===============================

// Module: seq_alu_disp
// PURPOSE
//  Parametrised sequential ALU for the board top level. Operands and op code are latched on a
//  start/done handshake. Single-cycle logic/add/sub ops and a multi-cycle shift-add multiplier.
//  Registered flags and a 7-seg decode of the result low nibble; drives SWI/LED/SEG of top.
// PARAMETERS
//  NBITS     4   operand/result width (2..16); ADD/SUB/XOR two's complement, MUL unsigned
// PORTS
//  clk_2     in   1      system clock (divided board clock)
//  reset_n   in   1      synchronous reset, active-low
//  start     in   1      request; sampled only when busy=0
//  op        in   3      0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 MUL, 6-7 reserved
//  a, b      in   NBITS  operands
//  result    out  NBITS  registered result, held until next completion
//  carry     out  1      ADD: carry-out; SUB: borrow (a<b unsigned); else 0
//  ovf       out  1      ADD/SUB: signed overflow; MUL: high half of product nonzero; else 0
//  zero      out  1      result==0
//  neg       out  1      result[NBITS-1]
//  busy      out  1      1 while multiplier iterates
//  done      out  1      one-cycle pulse when result/flags update
//  seg       out  8      {dp,g,f,e,d,c,b,a}, active-high; hex of result[3:0]; dp=ovf
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): state IDLE; result, flags, busy, done = 0; seg = 8'h3F ('0').
//    Reset wins over start on the same edge; reset during MUL aborts, no done pulse.
//  - FSM IDLE/MUL. IDLE + start: latch a,b,op.
//    Non-MUL op: result+flags written same edge, done=1 next cycle (latency 1), stay IDLE.
//    MUL: go MUL, busy=1, cnt=0, acc=0 (2*NBITS wide).
//  - MUL: each edge, if b_q[cnt] then acc += a_q<<cnt; cnt++. After NBITS iterations:
//    result=acc[NBITS-1:0], ovf=|acc[2NBITS-1:NBITS], done=1 next cycle, back to IDLE, busy=0.
//    Done visible NBITS+1 cycles after start edge.
//  - start while busy=1 ignored (not queued). start held high in IDLE restarts every cycle.
//  - ADD/SUB computed NBITS+1 wide; carry=bit NBITS (SUB: borrow); ovf from sign bits.
//    Results wrap modulo 2^NBITS.
//  - Reserved op: result=0, flags from 0 (zero=1), done still pulses.
//  - seg decoded combinationally from registered result/ovf; NBITS<4: zero-extend nibble.
//  - done deasserts after one cycle unless a new op completes.
// CONFIGURATION
//  ALU_SATURATE_EN defined: on ovf, ADD/SUB clamp to signed max (0111..) / min (1000..);
//    MUL clamps to all-ones. ovf, carry still report the event.
//  Undefined: wrap-around results as above.
// TESTING (NBITS=4)
//  AND a=C b=A start -> next cycle done=1, result=8, neg=1, zero=0
//  ADD a=7 b=1 -> result=8, ovf=1, carry=0, seg[7]=1; ALU_SATURATE_EN: result=7
//  SUB a=0 b=1 -> result=F, carry=1, ovf=0, neg=1, seg[6:0]=7'h71 ('F')
//  MUL a=3 b=5 -> busy 4 cycles, done 5 cycles after start, result=F, ovf=0;
//    start pulsed mid-MUL ignored
//  MUL a=5 b=4 -> result=4, ovf=1; ALU_SATURATE_EN: result=F
//  MUL a=F b=F, reset_n=0 on 2nd busy cycle -> busy=0, result=0, no done, seg=3F

Source files
------------

// File: rtl/seq_alu_disp_if.sv
// Handshake and result bus of the sequential ALU.
// master: the requester driving start/op/operands; slave: the ALU itself.
interface seq_alu_disp_if #(
  parameter int NBITS = 4
);
  logic             start;
  logic [2:0]       op;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic [NBITS-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic             busy;
  logic             done;
  logic [7:0]       seg;

  modport master (
    output start, op, a, b,
    input  result, carry, ovf, zero, neg, busy, done, seg
  );

  modport slave (
    input  start, op, a, b,
    output result, carry, ovf, zero, neg, busy, done, seg
  );
endinterface

// File: rtl/seq_alu_disp.sv
// Sequential ALU with start/done handshake, shift-add multiplier and 7-seg
// decode of the result low nibble.
// Optional feature macro: ALU_SATURATE_EN (clamp ADD/SUB/MUL on overflow).
//
// state  | meaning
// S_IDLE | waiting for start; single-cycle ops complete here
// S_MUL  | shift-add multiplier iterating, busy=1
module seq_alu_disp #(
  parameter int NBITS = 4
) (
  input  logic          clk_2,
  input  logic          reset_n,
  seq_alu_disp_if.slave bus
);

  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0]    LAST = CW'(NBITS - 1);
  localparam logic [NBITS-1:0] SMAX = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0] SMIN = {1'b1, {(NBITS-1){1'b0}}};
`ifdef ALU_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q, state_d;
  logic [NBITS-1:0]   a_q, a_d, b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*NBITS-1:0] acc_q, acc_d;
  logic [NBITS-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [NBITS:0]     sum, diff;
  logic               add_ovf, sub_ovf, mul_ovf;
  logic [2*NBITS-1:0] addend, acc_sum;
  logic [3:0]         nib;
  logic [6:0]         seg7;

  // Operand-path arithmetic, one bit wider to expose carry/borrow.
  assign sum     = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff    = {1'b0, bus.a} - {1'b0, bus.b};
  assign add_ovf = (bus.a[NBITS-1] == bus.b[NBITS-1]) && (sum[NBITS-1] != bus.a[NBITS-1]);
  assign sub_ovf = (bus.a[NBITS-1] != bus.b[NBITS-1]) && (diff[NBITS-1] != bus.a[NBITS-1]);
  assign addend  = b_q[cnt_q] ? ({{NBITS{1'b0}}, a_q} << cnt_q) : '0;
  assign acc_sum = acc_q + addend;
  assign mul_ovf = |acc_sum[2*NBITS-1:NBITS];

  // Next-state, operand latch and result/flag computation.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d = bus.a;
          b_d = bus.b;
          if (bus.op == 3'd5) begin
            state_d = S_MUL;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            done_d   = 1'b1;
            result_d = '0;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            case (bus.op)
              3'd0: result_d = bus.a & bus.b;
              3'd1: result_d = bus.a | bus.b;
              3'd2: begin
                result_d = sum[NBITS-1:0];
                carry_d  = sum[NBITS];
                ovf_d    = add_ovf;
                if (SAT_EN && add_ovf) result_d = bus.a[NBITS-1] ? SMIN : SMAX;
              end
              3'd3: begin
                result_d = diff[NBITS-1:0];
                carry_d  = diff[NBITS];
                ovf_d    = sub_ovf;
                if (SAT_EN && sub_ovf) result_d = bus.a[NBITS-1] ? SMIN : SMAX;
              end
              3'd4: result_d = bus.a ^ bus.b;
              default: result_d = '0;
            endcase
          end
        end
      end
      S_MUL: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          carry_d  = 1'b0;
          ovf_d    = mul_ovf;
          result_d = (SAT_EN && mul_ovf) ? '1 : acc_sum[NBITS-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset wins over start.
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Hex digit of the result low nibble, zero-extended for narrow results.
  assign nib = 4'(result_q);
  always_comb begin
    seg7 = 7'h00;
    case (nib)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      4'hF: seg7 = 7'h71;
      default: seg7 = 7'h00;
    endcase
  end

  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = (result_q == '0);
  assign bus.neg    = result_q[NBITS-1];
  assign bus.busy   = (state_q == S_MUL);
  assign bus.done   = done_q;
  assign bus.seg    = {ovf_q, seg7};

endmodule

// File: tb/tb_seq_alu_disp.sv
// Bench for seq_alu_disp at NBITS=4: directed cases plus random ops checked
// against an integer-arithmetic reference model.
module tb_seq_alu_disp;

`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seq_alu_disp_if #(.NBITS(4)) bus ();
  seq_alu_disp #(.NBITS(4)) dut (.clk_2(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic void model(input int op, input int a, input int b,
                                output int r, output int c, output int v);
    int t;
    r = 0; c = 0; v = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: begin
        t = sgn4(a) + sgn4(b);
        c = (a + b > 15) ? 1 : 0;
        v = (t > 7 || t < -8) ? 1 : 0;
        r = (a + b) % 16;
        if (SAT && v == 1) r = (t > 7) ? 7 : 8;
      end
      3: begin
        t = sgn4(a) - sgn4(b);
        c = (a < b) ? 1 : 0;
        v = (t > 7 || t < -8) ? 1 : 0;
        r = (a - b + 16) % 16;
        if (SAT && v == 1) r = (t > 7) ? 7 : 8;
      end
      4: r = a ^ b;
      5: begin
        v = (a * b > 15) ? 1 : 0;
        r = (a * b) % 16;
        if (SAT && v == 1) r = 15;
      end
      default: r = 0;
    endcase
  endfunction

  task automatic run_op(input int o, input int av, input int bv, input bit poke);
    int er, ec, ev, lat, cyc;
    model(o, av, bv, er, ec, ev);
    lat = (o == 5) ? 5 : 1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'(o);
    bus.a = 4'(av);
    bus.b = 4'(bv);
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 20) begin
      chk("busy_while_iterating", 32'(bus.busy), 32'(o == 5));
      if (poke && cyc == 2) begin
        bus.start = 1'b1;
        bus.op = 3'd2;
        bus.a = 4'h1;
        bus.b = 4'h1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(lat));
    chk("done", 32'(bus.done), 32'd1);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk("result", 32'(bus.result), 32'(er));
    chk("carry", 32'(bus.carry), 32'(ec));
    chk("ovf", 32'(bus.ovf), 32'(ev));
    chk("zero", 32'(bus.zero), 32'(er == 0));
    chk("neg", 32'(bus.neg), 32'(er >= 8));
    chk("seg", 32'(bus.seg), 32'({ev[0], seg_tab[er]}));
    @(posedge clk); #1;
    chk("done_pulse_end", 32'(bus.done), 32'd0);
    chk("result_held", 32'(bus.result), 32'(er));
  endtask

  initial begin
    int er, ec, ev, o, av, bv;
    bit saw_done;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = 4'h0;
    bus.b = 4'h0;

    // Reset state; start asserted during reset must be ignored.
    reset_n = 1'b0;
    bus.start = 1'b1;
    bus.op = 3'd2;
    bus.a = 4'h3;
    bus.b = 4'h4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_neg", 32'(bus.neg), 32'd0);
    chk("rst_seg", 32'(bus.seg), 32'h3F);
    @(negedge clk);
    bus.start = 1'b0;
    reset_n = 1'b1;

    // Directed cases.
    run_op(0, 'hC, 'hA, 1'b0);
    run_op(2, 7, 1, 1'b0);
    run_op(3, 0, 1, 1'b0);
    run_op(5, 3, 5, 1'b1);
    run_op(5, 5, 4, 1'b0);
    run_op(6, 9, 9, 1'b0);
    run_op(3, 8, 1, 1'b0);
    run_op(2, 'hF, 1, 1'b0);

    // Start held high in IDLE completes a new op every cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'd2;
    bus.b = 4'h1;
    for (int i = 0; i < 3; i++) begin
      bus.a = 4'(i + 2);
      @(posedge clk); #1;
      chk("held_done", 32'(bus.done), 32'd1);
      chk("held_result", 32'(bus.result), 32'(i + 3));
      @(negedge clk);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("held_release_done", 32'(bus.done), 32'd0);

    // Random ops against the model.
    for (int n = 0; n < 40; n++) begin
      o  = int'($urandom_range(0, 7));
      av = int'($urandom_range(0, 15));
      bv = int'($urandom_range(0, 15));
      run_op(o, av, bv, 1'b0);
    end

    // Reset during MUL aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'd5;
    bus.a = 4'hF;
    bus.b = 4'hF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("abort_busy1", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("abort_busy2", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_seg", 32'(bus.seg), 32'h3F);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    // Model sanity on a fresh op after the abort.
    model(4, 'h6, 'h3, er, ec, ev);
    run_op(4, 'h6, 'h3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
